instr_phase_sequencer: RTL and testbench
========================================

Name: instr_phase_sequencer

Overview:
- Multi-cycle control unit for the RV64 core.
- Generates the 3-bit `vital` phase code that gates the ALU and other phase-qualified datapath blocks.
- Strobes the IR, PC, register-file and data-memory enables per phase, and handles memory wait states via a ready handshake.
- Halts on illegal encodings or memory timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum wait cycles allowed in IF or MEM before timeout halt (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = keep issuing instructions.
- opcode  in  7  instruction opcode field from IR.
- func3  in  3  instruction func3 field from IR.
- branch_sel  in  3  ALU branch result; 3'b111 = not taken, any other value = taken.
- mem_ready  in  1  memory completed the current read or write this cycle.
- vital  out  3  phase code: 000 IF, 001 ID, 010 EX, 011 MEM, 100 WB, 111 IDLE/HALT.
- ir_load  out  1  load IR from fetch data.
- mem_re  out  1  memory read request (fetch or load).
- mem_we  out  1  memory write request (store).
- reg_we  out  1  register-file write enable.
- pc_we  out  1  PC update enable.
- pc_src  out  2  00 PC+1, 01 branch target, 10 jal_output, 11 jalr ALU out.
- busy  out  1  1 in any state other than IDLE/HALT.
- illegal  out  1  sticky; illegal instruction caused the halt.
- timeout  out  1  sticky; memory wait limit caused the halt.
- retired  out  CNT_W  count of instructions completed in WB.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - vital=111, pc_src=00, retired=0.
  - All other outputs 0.
  - Takes effect immediately, including mid-instruction; no partial writeback.
- All outputs are registered/Moore except ir_load, which is Mealy: IF & mem_ready.
- IDLE: go to IF on the cycle run=1.
- IF (vital=000):
  - mem_re=1 while waiting.
  - When mem_ready=1: ir_load=1 that cycle, then next state is ID.
- ID (vital=001): one cycle; latch opcode/func3 into an internal class register held through WB. Legal set:
  - I-type 0010011 with func3 000/001.
  - R-type 0110011.
  - Load 0000011 / store 0100011 with func3 011.
  - Branch 1100011 with func3 000/001/100/101.
  - jal 1101111.
  - jalr 1100111 with func3 000.
  - Any other encoding → HALT, illegal=1.
- EX (vital=010): exactly one cycle. Load/store → MEM; all other classes → WB.
- MEM (vital=011):
  - mem_re=1 (load) or mem_we=1 (store) until mem_ready.
  - Then → WB.
- WB (vital=100): one cycle.
  - reg_we=1 for I, R, load, jal, jalr.
  - pc_we=1 always.
  - pc_src selection: branch with branch_sel!=111 → 01; branch not taken → 00; jal → 10; jalr → 11; otherwise 00.
  - retired increments, wrapping at 2^CNT_W.
  - Next state: IF if run=1, else IDLE.
- Latency with zero-wait memory:
  - 4 cycles for ALU, branch and jump instructions.
  - 5 cycles for load/store.
- Wait counter: cleared on entry to IF/MEM; increments each cycle mem_ready=0.
  - When it reaches MEM_WAIT_MAX with mem_ready still 0 → HALT, timeout=1.
  - mem_ready=1 in the same cycle the limit is reached: ready wins and there is no timeout.
- run=0 mid-instruction: the current instruction completes through WB, then IDLE.
- HALT: vital=111, busy=0, all enables 0; exited only by reset.

Test Plan:
- Reset then run=1, addi (opcode 0010011, func3 000), mem_ready always 1 → vital 000,001,010,100,000; reg_we=1 and pc_we=1 with pc_src=00 in WB only; retired=1 after 4 cycles.
- Load (0000011, func3 011), mem_ready low for 3 cycles in MEM → vital holds 011 with mem_re=1 for 4 cycles; reg_we in WB; 8 cycles total.
- beq (1100011, func3 000) with branch_sel=000 → pc_src=01, reg_we=0; repeat with branch_sel=111 → pc_src=00.
- Fetch with mem_ready stuck 0, MEM_WAIT_MAX=15 → HALT after the 15th wait cycle: timeout=1, vital=111, busy=0. Repeat with mem_ready rising on the 15th cycle → ID follows, timeout=0.
- opcode 0110111 decoded in ID → HALT with illegal=1; retired unchanged; rst_n pulse clears illegal and returns to IDLE.
- Assert rst_n=0 mid-MEM of a store → mem_we drops within the same cycle without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/instr_phase_sequencer_if.sv
// Control bus between the phase sequencer and the RV64 datapath/memory.
// master: the sequencer (drives phase code and strobes).
// slave: the datapath side (drives instruction fields, branch result, memory ready).
interface instr_phase_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [2:0]       branch_sel;
    logic             mem_ready;
    logic [2:0]       vital;
    logic             ir_load;
    logic             mem_re;
    logic             mem_we;
    logic             reg_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, func3, branch_sel, mem_ready,
        output vital, ir_load, mem_re, mem_we, reg_we, pc_we, pc_src,
        output busy, illegal, timeout, retired
    );

    modport slave (
        output run, opcode, func3, branch_sel, mem_ready,
        input  vital, ir_load, mem_re, mem_we, reg_we, pc_we, pc_src,
        input  busy, illegal, timeout, retired
    );
endinterface

// File: rtl/instr_phase_sequencer.sv
// Multi-cycle phase sequencer: IF -> ID -> EX -> [MEM] -> WB.
// Phase code and strobes are decoded from registered state (Moore), except
// ir_load which follows mem_ready during IF. Halts on illegal encodings or on
// a memory wait exceeding MEM_WAIT_MAX cycles; only reset leaves HALT.
module instr_phase_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    instr_phase_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StEx   = 3'b010,
        StMem  = 3'b011,
        StWb   = 3'b100,
        StIdle = 3'b101,
        StHalt = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr,
        ClsIllegal
    } cls_e;

    // Wait counter value at which a still-unready cycle is the last allowed one.
    localparam logic [7:0] WaitLimit = 8'(MEM_WAIT_MAX - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, dec_cls;
    logic             taken_q, taken_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [2:0] vital;
    logic       mem_re, mem_we, reg_we, pc_we, busy;
    logic [1:0] pc_src;

    // Classify the live IR fields; anything outside the legal set is illegal.
    always_comb begin
        dec_cls = ClsIllegal;
        case (bus.opcode)
            7'b0010011: if (bus.func3 == 3'b000 || bus.func3 == 3'b001) dec_cls = ClsAlu;
            7'b0110011: dec_cls = ClsAlu;
            7'b0000011: if (bus.func3 == 3'b011) dec_cls = ClsLoad;
            7'b0100011: if (bus.func3 == 3'b011) dec_cls = ClsStore;
            7'b1100011: begin
                if (bus.func3 == 3'b000 || bus.func3 == 3'b001 ||
                    bus.func3 == 3'b100 || bus.func3 == 3'b101) begin
                    dec_cls = ClsBranch;
                end
            end
            7'b1101111: dec_cls = ClsJal;
            7'b1100111: if (bus.func3 == 3'b000) dec_cls = ClsJalr;
            default: dec_cls = ClsIllegal;
        endcase
    end

    // Next-state, wait counter, class latch, retire counter and sticky halt causes.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        taken_d   = taken_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d = StIf;
                    wait_d  = 8'd0;
                end
            end
            StIf: begin
                // Ready wins over the limit when both land on the same cycle.
                if (bus.mem_ready) begin
                    state_d = StId;
                end else if (wait_q == WaitLimit) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StId: begin
                if (dec_cls == ClsIllegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    cls_d   = dec_cls;
                    state_d = StEx;
                end
            end
            StEx: begin
                // Capture the ALU branch result while the ALU is gated by EX.
                taken_d = (bus.branch_sel != 3'b111);
                if (cls_q == ClsLoad || cls_q == ClsStore) begin
                    state_d = StMem;
                    wait_d  = 8'd0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (bus.mem_ready) begin
                    state_d = StWb;
                end else if (wait_q == WaitLimit) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWb: begin
                retired_d = retired_q + CNT_W'(1);
                wait_d    = 8'd0;
                state_d   = bus.run ? StIf : StIdle;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State and bookkeeping registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cls_q     <= ClsAlu;
            taken_q   <= 1'b0;
            wait_q    <= 8'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            taken_q   <= taken_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore decode of phase code and per-phase strobes.
    always_comb begin
        vital  = 3'b111;
        mem_re = 1'b0;
        mem_we = 1'b0;
        reg_we = 1'b0;
        pc_we  = 1'b0;
        pc_src = 2'b00;
        busy   = 1'b1;
        unique case (state_q)
            StIf: begin
                vital  = 3'b000;
                mem_re = 1'b1;
            end
            StId: vital = 3'b001;
            StEx: vital = 3'b010;
            StMem: begin
                vital  = 3'b011;
                mem_re = (cls_q == ClsLoad);
                mem_we = (cls_q == ClsStore);
            end
            StWb: begin
                vital  = 3'b100;
                pc_we  = 1'b1;
                reg_we = (cls_q == ClsAlu) || (cls_q == ClsLoad) ||
                         (cls_q == ClsJal) || (cls_q == ClsJalr);
                case (cls_q)
                    ClsBranch: pc_src = taken_q ? 2'b01 : 2'b00;
                    ClsJal:    pc_src = 2'b10;
                    ClsJalr:   pc_src = 2'b11;
                    default:   pc_src = 2'b00;
                endcase
            end
            default: busy = 1'b0;
        endcase
    end

    assign bus.vital   = vital;
    assign bus.mem_re  = mem_re;
    assign bus.mem_we  = mem_we;
    assign bus.reg_we  = reg_we;
    assign bus.pc_we   = pc_we;
    assign bus.pc_src  = pc_src;
    assign bus.busy    = busy;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.retired = retired_q;
    assign bus.ir_load = (state_q == StIf) && bus.mem_ready;

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Scoreboard bench for instr_phase_sequencer: the stimulus process drives one
// cycle at a time and queues the expected output snapshot for that cycle; the
// monitor pops and compares at each falling edge or on an explicit sample event.
module tb_instr_phase_sequencer;

    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLd  = 7'b0000011;
    localparam logic [6:0] OpSt  = 7'b0100011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
    localparam logic [6:0] OpJlr = 7'b1100111;
    localparam logic [6:0] OpLui = 7'b0110111;

    typedef struct {
        string       name;
        logic [44:0] bits;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    event sample_ev;

    instr_phase_sequencer_if #(.CNT_W(32)) bus ();

    instr_phase_sequencer #(
        .MEM_WAIT_MAX(15),
        .CNT_W       (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input logic [44:0] b);
        return $sformatf("vital=%b irl=%b re=%b we=%b rwe=%b pwe=%b src=%b busy=%b ill=%b to=%b ret=%0d",
                         b[44:42], b[41], b[40], b[39], b[38], b[37], b[36:35], b[34], b[33],
                         b[32], b[31:0]);
    endfunction

    // Queue one expected snapshot; busy is 1 exactly when vital is not 111.
    task automatic ex(input string nm, input logic [2:0] v, input logic irl, input logic re,
                      input logic we, input logic rw, input logic pw, input logic [1:0] src,
                      input logic ill, input logic to, input logic [31:0] ret);
        exp_t e;
        e.name = nm;
        e.bits = {v, irl, re, we, rw, pw, src, (v != 3'b111), ill, to, ret};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic reset_pulse(input string nm);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ex(nm, 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        ->sample_ev;
        #1;
    endtask

    // Non-memory instruction with zero-wait fetch: IF, ID, EX, WB.
    task automatic run_short(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [2:0] bsel, input logic rw, input logic [1:0] src,
                             input logic [31:0] ret);
        tick();
        bus.opcode = op; bus.func3 = f3; bus.branch_sel = bsel; bus.mem_ready = 1'b1;
        ex({nm, "_if"}, 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, ret);
        tick(); ex({nm, "_id"}, 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, ret);
        tick(); ex({nm, "_ex"}, 3'b010, 0, 0, 0, 0, 0, 2'b00, 0, 0, ret);
        tick(); ex({nm, "_wb"}, 3'b100, 0, 0, 0, rw, 1, src, 0, 0, ret);
    endtask

    // Monitor: compare DUT outputs against the head of the expectation queue.
    initial begin
        exp_t        e;
        logic [44:0] act;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.vital, bus.ir_load, bus.mem_re, bus.mem_we, bus.reg_we, bus.pc_we,
                       bus.pc_src, bus.busy, bus.illegal, bus.timeout, bus.retired};
                n_checks++;
                if (act === e.bits) n_pass++;
                else $display("FAIL %s: got %s want %s", e.name, fmt(act), fmt(e.bits));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus
    initial begin
        rst_n = 1'b1;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 7'd0; bus.func3 = 3'd0;
        bus.branch_sel = 3'b111;
        #1 rst_n = 1'b0;
        #2;
        ex("reset", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        ->sample_ev;
        tick();
        rst_n = 1'b1;
        ex("idle0", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        // addi, zero-wait
        tick();
        bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OpI; bus.func3 = 3'b000;
        ex("idle_run", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        run_short("addi", OpI, 3'b000, 3'b111, 1, 2'b00, 0);

        // load with three wait cycles in MEM
        tick(); bus.opcode = OpLd; bus.func3 = 3'b011;
        ex("ld_if", 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, 1);
        tick(); ex("ld_id", 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        tick(); bus.mem_ready = 1'b0;
        ex("ld_ex", 3'b010, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); ex("ld_mem_wait", 3'b011, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1);
        end
        tick(); bus.mem_ready = 1'b1;
        ex("ld_mem_rdy", 3'b011, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1);
        tick(); ex("ld_wb", 3'b100, 0, 0, 0, 1, 1, 2'b00, 0, 0, 1);

        // branches and jumps
        run_short("beq_taken", OpBr, 3'b000, 3'b000, 0, 2'b01, 2);
        run_short("beq_not",   OpBr, 3'b000, 3'b111, 0, 2'b00, 3);
        run_short("jal",       OpJal, 3'b010, 3'b111, 1, 2'b10, 4);
        run_short("jalr",      OpJlr, 3'b000, 3'b111, 1, 2'b11, 5);

        // store, run dropped mid-instruction -> completes, then IDLE
        tick(); bus.opcode = OpSt; bus.func3 = 3'b011;
        ex("st_if", 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, 6);
        tick(); bus.run = 1'b0;
        ex("st_id", 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 6);
        tick(); ex("st_ex",  3'b010, 0, 0, 0, 0, 0, 2'b00, 0, 0, 6);
        tick(); ex("st_mem", 3'b011, 0, 0, 1, 0, 0, 2'b00, 0, 0, 6);
        tick(); ex("st_wb",  3'b100, 0, 0, 0, 0, 1, 2'b00, 0, 0, 6);
        tick(); ex("idle_after_stop", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 7);
        tick(); ex("idle_hold", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 7);

        // fetch ready arrives on the 15th cycle: no timeout
        tick(); bus.run = 1'b1; bus.mem_ready = 1'b0; bus.opcode = OpI; bus.func3 = 3'b001;
        ex("idle_go", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 7);
        for (int i = 0; i < 14; i++) begin
            tick(); ex("if_wait", 3'b000, 0, 1, 0, 0, 0, 2'b00, 0, 0, 7);
        end
        tick(); bus.mem_ready = 1'b1;
        ex("if_ready_at_limit", 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, 7);
        tick(); ex("id_after_limit", 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 7);
        tick(); ex("ex_after_limit", 3'b010, 0, 0, 0, 0, 0, 2'b00, 0, 0, 7);
        tick(); ex("wb_after_limit", 3'b100, 0, 0, 0, 1, 1, 2'b00, 0, 0, 7);

        // illegal opcode (lui) -> HALT, retired unchanged
        tick(); bus.opcode = OpLui; bus.func3 = 3'b000;
        ex("ill_if", 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, 8);
        tick(); ex("ill_id",   3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 8);
        tick(); ex("ill_halt", 3'b111, 0, 0, 0, 0, 0, 2'b00, 1, 0, 8);
        tick(); ex("ill_hold", 3'b111, 0, 0, 0, 0, 0, 2'b00, 1, 0, 8);
        reset_pulse("ill_reset");
        tick(); rst_n = 1'b1; bus.mem_ready = 1'b0; bus.opcode = OpI;
        ex("idle_post_rst", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        // fetch stuck: HALT after the 15th wait cycle
        for (int i = 0; i < 15; i++) begin
            tick(); ex("if_stuck", 3'b000, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        end
        tick(); ex("timeout_halt", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        tick(); bus.mem_ready = 1'b1;
        ex("timeout_hold", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        reset_pulse("to_reset");

        // store interrupted by reset during MEM
        tick(); rst_n = 1'b1; bus.opcode = OpSt; bus.func3 = 3'b011;
        ex("idle_post_rst2", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick(); ex("st2_if", 3'b000, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        tick(); ex("st2_id", 3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick(); bus.mem_ready = 1'b0;
        ex("st2_ex", 3'b010, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick(); ex("st2_mem", 3'b011, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0);
        reset_pulse("st_mid_reset");
        tick(); rst_n = 1'b1; bus.run = 1'b0;
        ex("idle_final", 3'b111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d unchecked expectations want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
